// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit for the execute stage.
// Computes MUL/DIV/DIVU/REM/REMU and their 32-bit W forms at one bit per cycle.
// Divide-by-zero, signed overflow and reserved ops finish in one cycle without iterating.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   in_valid / in_ready  request handshake (in_ready while idle)
//   op, word, a, b       operation, W-variant select, operands (sampled on accept)
//   flush                abort any operation in flight; the request is not accepted
//   out_valid/out_ready  result handshake; result is held until taken
//   result               result value, stable while out_valid
//   busy                 iterating
module muldiv_unit #(
    parameter int unsigned XLEN     = 64,
    parameter bit          W_ENABLE = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [2:0] OpMul  = 3'd0;
    localparam logic [2:0] OpDiv  = 3'd1;
    localparam logic [2:0] OpDivu = 3'd2;
    localparam logic [2:0] OpRem  = 3'd3;
    localparam logic [2:0] OpRemu = 3'd4;

    localparam int unsigned CntW = $clog2(XLEN + 1);

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = '0;
        r[31:0] = v;
        return r;
    endfunction

    logic [1:0]      state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic            word_q, word_d;
    logic            quo_neg_q, quo_neg_d;
    logic            rem_neg_q, rem_neg_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    // x: multiplier / quotient shift register, y: multiplicand / |divisor|,
    // z: product accumulator / partial remainder
    logic [XLEN-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic [XLEN-1:0] result_q, result_d;

    // Request decode, evaluated on the incoming operands
    logic            word_eff, is_mul, is_signed, is_quo, is_reserved;
    logic            a_neg, b_neg, div_zero, div_ovf, special;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val, spec_res;

    always_comb begin
        word_eff    = (W_ENABLE && (XLEN == 64)) ? word : 1'b0;
        is_mul      = (op == OpMul);
        is_signed   = (op == OpDiv) || (op == OpRem);
        is_quo      = (op == OpDiv) || (op == OpDivu);
        is_reserved = (op > OpRemu);
        if (word_eff) begin
            a_ext   = is_signed ? sext32(a[31:0]) : zext32(a[31:0]);
            b_ext   = is_signed ? sext32(b[31:0]) : zext32(b[31:0]);
            min_val = sext32(32'h8000_0000);
        end else begin
            a_ext   = a;
            b_ext   = b;
            min_val = {1'b1, {(XLEN-1){1'b0}}};
        end
        a_neg    = is_signed && a_ext[XLEN-1];
        b_neg    = is_signed && b_ext[XLEN-1];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        div_zero = (b_ext == '0);
        div_ovf  = is_signed && (a_ext == min_val) && (b_ext == '1);
        special  = is_reserved || (!is_mul && (div_zero || div_ovf));
        spec_res = '0;
        if (!is_reserved && !is_mul) begin
            if (div_zero) begin
                spec_res = is_quo ? '1 : a_ext;
            end else if (div_ovf) begin
                spec_res = is_quo ? a_ext : '0;
            end
        end
        if (word_eff) begin
            spec_res = sext32(spec_res[31:0]);
        end
    end

    logic [XLEN:0]   rem_sh;
    logic            ge;
    logic [XLEN-1:0] fin;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        word_d    = word_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        result_d  = result_q;
        rem_sh    = {z_q, x_q[XLEN-1]};
        ge        = (rem_sh >= {1'b0, y_q});
        fin       = '0;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_d      = op;
                    word_d    = word_eff;
                    quo_neg_d = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    cnt_d     = word_eff ? CntW'(32) : CntW'(XLEN);
                    z_d       = '0;
                    if (is_mul) begin
                        x_d = b_ext;
                        y_d = a_ext;
                    end else begin
                        // Left-align a W dividend so the MSB always enters from x[XLEN-1]
                        x_d = word_eff ? (a_mag << (XLEN - 32)) : a_mag;
                        y_d = b_mag;
                    end
                    if (special) begin
                        state_d  = StDone;
                        result_d = spec_res;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                if (op_q == OpMul) begin
                    z_d = z_q + (x_q[0] ? y_q : '0);
                    y_d = y_q << 1;
                    x_d = x_q >> 1;
                end else begin
                    z_d = ge ? (rem_sh[XLEN-1:0] - y_q) : rem_sh[XLEN-1:0];
                    x_d = {x_q[XLEN-2:0], ge};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    case (op_q)
                        OpDiv:   fin = quo_neg_q ? -x_d : x_d;
                        OpDivu:  fin = x_d;
                        OpRem:   fin = rem_neg_q ? -z_d : z_d;
                        default: fin = z_d;
                    endcase
                    state_d  = StDone;
                    result_d = word_q ? sext32(fin[31:0]) : fin;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (flush) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            op_q      <= '0;
            word_q    <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            cnt_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            word_q    <= word_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            result_q  <= result_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StCalc);
    assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed bench for muldiv_unit (XLEN=64). Each request pushes its expected
// result and first-valid cycle into a queue; a monitor pops and compares on out_valid.
module tb_muldiv_unit;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        in_valid  = 1'b0;
    logic        word      = 1'b0;
    logic        flush     = 1'b0;
    logic        out_ready = 1'b1;
    logic [2:0]  op        = 3'd0;
    logic [63:0] a         = 64'd0;
    logic [63:0] b         = 64'd0;
    logic        in_ready, out_valid, busy;
    logic [63:0] result;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [63:0] res;
        int          cyc;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    muldiv_unit #(.XLEN(64), .W_ENABLE(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .word      (word),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare once per result, at the first cycle out_valid is seen.
    initial begin : monitor
        exp_t e;
        logic seen;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (reset || !out_valid) begin
                seen = 1'b0;
            end else begin
                if (!seen) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out_valid: got result %h at cycle %0d expected none",
                                 result, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check({e.name, "_result"}, result, e.res);
                        check({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
                    end
                end
                seen = !out_ready;
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic w, input logic [63:0] x,
                         input logic [63:0] y, output int t);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) check("issue_in_ready", {63'd0, in_ready}, 64'd1);
        op = o; word = w; a = x; b = y; in_valid = 1'b1;
        t = cyc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (!(in_ready && exp_q.size() == 0) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no result within 300 cycles expected one", name);
            exp_q.delete();
        end
    endtask

    task automatic send(input string name, input logic [2:0] o, input logic w,
                        input logic [63:0] x, input logic [63:0] y,
                        input logic [63:0] exp, input int lat);
        int   t;
        exp_t e;
        issue(o, w, x, y, t);
        e.res = exp; e.cyc = t + lat; e.name = name;
        exp_q.push_back(e);
        wait_drain(name);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int   t;
        int   n;
        logic any_valid;
        exp_t e;

        repeat (3) tick();
        reset = 1'b0;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_result", result, 64'd0);

        // 64-bit iterative ops: out_valid at t+65
        send("mul_7_m3", 3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
        send("div_m7_2", 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        send("rem_m7_2", 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ALL1, 65);
        send("divu_100_7", 3'd2, 1'b0, 64'd100, 64'd7, 64'd14, 65);
        send("remu_100_7", 3'd4, 1'b0, 64'd100, 64'd7, 64'd2, 65);
        send("div_20_m6", 3'd1, 1'b0, 64'd20, 64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        send("rem_20_m6", 3'd3, 1'b0, 64'd20, 64'hFFFF_FFFF_FFFF_FFFA, 64'd2, 65);
        send("mul_wrap", 3'd0, 1'b0, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 65);

        // One-cycle special cases
        send("divu_5_0", 3'd2, 1'b0, 64'd5, 64'd0, ALL1, 1);
        send("rem_5_0", 3'd3, 1'b0, 64'd5, 64'd0, 64'd5, 1);
        send("div_ovf", 3'd1, 1'b0, 64'h8000_0000_0000_0000, ALL1, 64'h8000_0000_0000_0000, 1);
        send("rem_ovf", 3'd3, 1'b0, 64'h8000_0000_0000_0000, ALL1, 64'd0, 1);
        send("divw_ovf", 3'd1, 1'b1, 64'h1_8000_0000, ALL1, 64'hFFFF_FFFF_8000_0000, 1);
        send("remuw_0", 3'd4, 1'b1, 64'h1_8000_0005, 64'h1_0000_0000, 64'hFFFF_FFFF_8000_0005, 1);
        send("reserved5", 3'd5, 1'b0, 64'd9, 64'd3, 64'd0, 1);

        // W iterative ops: out_valid at t+33
        send("divuw_100_7", 3'd2, 1'b1, 64'hFFFF_FFFF_0000_0064, 64'd7, 64'd14, 33);
        send("remw_m7_2", 3'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ALL1, 33);

        // MULW with the consumer stalled for 5 cycles
        out_ready = 1'b0;
        issue(3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, t);
        e.res = 64'hFFFF_FFFF_FFFF_FFFE; e.cyc = t + 33; e.name = "mulw_hold";
        exp_q.push_back(e);
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_out_valid", {63'd0, out_valid}, 64'd1);
            check("hold_result", result, 64'hFFFF_FFFF_FFFF_FFFE);
            check("hold_in_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        wait_drain("mulw_hold");

        // Flush at the 10th CALC cycle
        issue(3'd1, 1'b0, 64'd100, 64'd7, t);
        repeat (9) tick();
        check("flush_pre_busy", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", {63'd0, busy}, 64'd0);
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        any_valid = 1'b0;
        for (int i = 0; i < 70; i++) begin
            tick();
            any_valid = any_valid | out_valid;
        end
        check("flush_no_valid", {63'd0, any_valid}, 64'd0);
        send("after_flush_divu", 3'd2, 1'b0, 64'd100, 64'd7, 64'd14, 65);

        // Flush together with in_valid in IDLE: request is dropped
        op = 3'd0; word = 1'b0; a = 64'd3; b = 64'd4;
        in_valid = 1'b1;
        flush = 1'b1;
        tick();
        in_valid = 1'b0;
        flush = 1'b0;
        check("flush_acc_in_ready", {63'd0, in_ready}, 64'd1);
        check("flush_acc_busy", {63'd0, busy}, 64'd0);
        any_valid = 1'b0;
        for (int i = 0; i < 70; i++) begin
            tick();
            any_valid = any_valid | out_valid;
        end
        check("flush_acc_no_valid", {63'd0, any_valid}, 64'd0);

        // Reset mid-CALC (result currently holds 14)
        issue(3'd0, 1'b0, 64'd3, 64'd5, t);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstcalc_out_valid", {63'd0, out_valid}, 64'd0);
        check("rstcalc_result", result, 64'd0);
        check("rstcalc_busy", {63'd0, busy}, 64'd0);
        check("rstcalc_in_ready", {63'd0, in_ready}, 64'd1);
        send("mul_after_rst", 3'd0, 1'b0, 64'h1_2345_6789, 64'h10, 64'h12_3456_7890, 65);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
